uart_frame_tx: RTL and testbench
================================

// Module: uart_frame_tx
// PURPOSE
//  Parametrised frame serializer between a wide parallel payload and the byte-level UART
//  transmitter. A send request snapshots NUM_BYTES of payload, then streams an optional
//  header byte, the payload (selectable byte order) and an optional mod-256 checksum byte,
//  one byte per uart_send/uart_send_done handshake. It ends with a one-cycle send_done.
// PARAMETERS
//  NUM_BYTES    40      payload bytes per frame (>=1); data width = NUM_BYTES*8
//  MSB_FIRST    0       0: byte 0 = data[7:0] sent first; 1: data[NUM_BYTES*8-1 -:8] first
//  HEADER_EN    1       1: prepend HEADER_BYTE to every frame
//  HEADER_BYTE  8'hAA   header value
//  CSUM_EN      1       1: append checksum byte = sum of payload bytes mod 256
// PORTS
//  clk             in   1              system clock, all state on rising edge
//  rst             in   1              asynchronous, active-low reset
//  send            in   1              frame request, level-sampled in IDLE only
//  data            in   NUM_BYTES*8    payload, sampled only on the accepting edge
//  uart_send       out  1              byte request to UART TX, held until uart_send_done
//  send_data       out  8              byte for UART TX, stable while uart_send=1
//  uart_send_done  in   1              UART TX byte-complete, >=1 cycle high
//  busy            out  1              high in every state except IDLE
//  send_done       out  1              one-cycle pulse after last byte's uart_send_done
//  sta             out  2              current state code (debug)
// BEHAVIOUR
//  - FRAME_LEN = HEADER_EN + NUM_BYTES + CSUM_EN. Index counter width $clog2(FRAME_LEN+1).
//  - All outputs registered. Reset: uart_send=0, send_data=0, busy=0, send_done=0,
//    sta=IDLE, index=0, checksum=0, snapshot=0.
//  - States (sta code): IDLE=0, WAIT=1, GAP=2, DONE=3.
//  - IDLE: on an edge with send=1: snapshot<=data, index<=1, checksum<=0 (or first payload
//    byte if HEADER_EN=0), send_data<=byte 0 of frame, uart_send<=1, busy<=1, -> WAIT.
//    uart_send therefore rises one cycle after send is sampled.
//  - WAIT: uart_send held 1, send_data held. On uart_send_done=1: uart_send<=0, -> GAP.
//  - GAP: uart_send is 0 for exactly one cycle (guaranteed low gap between bytes).
//    If index<FRAME_LEN: send_data<=frame byte[index], uart_send<=1, index++, -> WAIT.
//    Else: send_done<=1, -> DONE.
//  - DONE: send_done high for this cycle only; busy<=0 on exit; -> IDLE.
//  - Checksum accumulates each payload byte as it is loaded into send_data; the checksum
//    slot sends the accumulated value; header bytes are not summed. 8-bit wrap-around.
//  - Byte order: payload slot k maps to snapshot byte k (MSB_FIRST=0) or NUM_BYTES-1-k.
//  - send is ignored outside IDLE; data changes after acceptance do not affect the frame.
//  - send still high when IDLE is re-entered starts a new frame on that edge (back-to-back
//    frames, gap of IDLE+DONE cycles between them). No edge detection.
//  - uart_send_done in IDLE, GAP or DONE is ignored. A done held high across GAP does not
//    complete the next byte early: WAIT entry is after GAP, done must be high in WAIT.
//    (UART TX guarantees done drops within one cycle of uart_send falling.)
//  - Reset asserted mid-frame: immediate return to reset values, no send_done pulse,
//    partial frame abandoned.
//  - Minimum frame time: 1 + FRAME_LEN*(2 + TX byte time) + 1 cycles.
// STRUCTURE
//  - Shared package uart_pkg: state codes (UART_IDLE..UART_DONE), STA_W=2, default
//    HEADER_BYTE, and the frame-length / index-width calculation function.
//  - Sub-module uart_byte_sel: combinational slot->byte mux (header / payload with
//    MSB_FIRST mapping / checksum) from snapshot, index and checksum. FSM, counters and
//    checksum register remain in uart_frame_tx.
// TESTING
//  - NUM_BYTES=4, defaults, data=32'h04030201, TX model done after 10 cycles -> bytes
//    AA,01,02,03,04,0A; one send_done pulse; busy low afterwards.
//  - MSB_FIRST=1, HEADER_EN=0, CSUM_EN=0, data=32'hDEADBEEF -> bytes DE,AD,BE,EF only.
//  - Checksum wrap: payload FF,FF,03 -> checksum 01; data changed to 0 during frame ->
//    bytes unchanged.
//  - send held high for 3 frames -> 3 complete frames, 3 send_done pulses, uart_send low
//    >=1 cycle between every byte; send pulse while busy -> no extra frame.
//  - Reset pulled low while in WAIT of byte 2 -> all outputs 0 asynchronously, sta=0,
//    no send_done; next send -> full frame from header.
//  - uart_send_done stuck high 1 cycle beyond GAP / spurious in IDLE -> no skipped
//    bytes, no state change in IDLE.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART frame transmitter.
// State codes, status width, default header and frame sizing.
package uart_pkg;

    localparam int STA_W = 2;

    typedef enum logic [STA_W-1:0] {
        UART_IDLE = 2'd0,
        UART_WAIT = 2'd1,
        UART_GAP  = 2'd2,
        UART_DONE = 2'd3
    } uart_state_e;

    localparam logic [7:0] HDR_DEFAULT = 8'hAA;

    function automatic int frame_len(input int nb, input bit hdr, input bit cs);
        return nb + (hdr ? 1 : 0) + (cs ? 1 : 0);
    endfunction

    function automatic int idx_w(input int nb, input bit hdr, input bit cs);
        return $clog2(frame_len(nb, hdr, cs) + 1);
    endfunction

endpackage

// File: rtl/uart_byte_sel.sv
// Combinational frame slot to byte mux.
// Slot 0 may be the header, then payload, then the checksum.
module uart_byte_sel
    import uart_pkg::*;
#(
    parameter int         NUM_BYTES   = 40,
    parameter bit         MSB_FIRST   = 1'b0,
    parameter bit         HEADER_EN   = 1'b1,
    parameter logic [7:0] HEADER_BYTE = HDR_DEFAULT,
    parameter bit         CSUM_EN     = 1'b1,
    parameter int         IW          = idx_w(NUM_BYTES, HEADER_EN, CSUM_EN)
) (
    input  logic [NUM_BYTES*8-1:0] src_i,
    input  logic [IW-1:0]          slot_i,
    input  logic [7:0]             csum_i,
    output logic [7:0]             byte_o,
    output logic                   payload_o
);

    localparam int HW = HEADER_EN ? 1 : 0;
    localparam int PW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    logic [7:0]    pb [NUM_BYTES];
    logic [IW-1:0] k;
    logic [PW-1:0] pidx;

    for (genvar g = 0; g < NUM_BYTES; g++) begin : g_bytes
        assign pb[g] = src_i[8*g +: 8];
    end

    assign k    = slot_i - IW'(HW);
    assign pidx = MSB_FIRST ? (PW'(NUM_BYTES - 1) - k[PW-1:0]) : k[PW-1:0];

    always_comb begin
        byte_o    = '0;
        payload_o = 1'b0;
        if (HEADER_EN && slot_i == '0) begin
            byte_o = HEADER_BYTE;
        end else if (k < IW'(NUM_BYTES)) begin
            byte_o    = pb[pidx];
            payload_o = 1'b1;
        end else if (CSUM_EN) begin
            byte_o = csum_i;
        end
    end

endmodule

// File: rtl/uart_frame_tx.sv
// Frame serializer: snapshots a wide payload and streams header,
// payload and checksum bytes over a send/done byte handshake.
module uart_frame_tx
    import uart_pkg::*;
#(
    parameter int         NUM_BYTES   = 40,
    parameter bit         MSB_FIRST   = 1'b0,
    parameter bit         HEADER_EN   = 1'b1,
    parameter logic [7:0] HEADER_BYTE = HDR_DEFAULT,
    parameter bit         CSUM_EN     = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   send,
    input  logic [NUM_BYTES*8-1:0] data,
    output logic                   uart_send,
    output logic [7:0]             send_data,
    input  logic                   uart_send_done,
    output logic                   busy,
    output logic                   send_done,
    output logic [STA_W-1:0]       sta
);

    localparam int FRAME_LEN = frame_len(NUM_BYTES, HEADER_EN, CSUM_EN);
    localparam int IW        = idx_w(NUM_BYTES, HEADER_EN, CSUM_EN);

    uart_state_e            state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [7:0]             csum_q, csum_d;
    logic [NUM_BYTES*8-1:0] snap_q, snap_d;
    logic                   us_q, us_d;
    logic [7:0]             sdata_q, sdata_d;
    logic                   busy_q, busy_d;
    logic                   sdone_q, sdone_d;

    logic [NUM_BYTES*8-1:0] sel_src;
    logic [IW-1:0]          sel_slot;
    logic [7:0]             sel_byte;
    logic                   sel_pay;

    // In IDLE the first byte comes straight from data, the snapshot loads alongside
    assign sel_src  = (state_q == UART_IDLE) ? data : snap_q;
    assign sel_slot = (state_q == UART_IDLE) ? '0 : idx_q;

    uart_byte_sel #(
        .NUM_BYTES   (NUM_BYTES),
        .MSB_FIRST   (MSB_FIRST),
        .HEADER_EN   (HEADER_EN),
        .HEADER_BYTE (HEADER_BYTE),
        .CSUM_EN     (CSUM_EN),
        .IW          (IW)
    ) u_sel (
        .src_i     (sel_src),
        .slot_i    (sel_slot),
        .csum_i    (csum_q),
        .byte_o    (sel_byte),
        .payload_o (sel_pay)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        snap_d  = snap_q;
        us_d    = us_q;
        sdata_d = sdata_q;
        busy_d  = busy_q;
        sdone_d = 1'b0;
        unique case (state_q)
            UART_IDLE: begin
                if (send) begin
                    snap_d  = data;
                    idx_d   = IW'(1);
                    csum_d  = sel_pay ? sel_byte : 8'h00;
                    sdata_d = sel_byte;
                    us_d    = 1'b1;
                    busy_d  = 1'b1;
                    state_d = UART_WAIT;
                end
            end
            UART_WAIT: begin
                if (uart_send_done) begin
                    us_d    = 1'b0;
                    state_d = UART_GAP;
                end
            end
            UART_GAP: begin
                if (idx_q < IW'(FRAME_LEN)) begin
                    sdata_d = sel_byte;
                    us_d    = 1'b1;
                    idx_d   = idx_q + IW'(1);
                    if (sel_pay) begin
                        csum_d = csum_q + sel_byte;
                    end
                    state_d = UART_WAIT;
                end else begin
                    sdone_d = 1'b1;
                    state_d = UART_DONE;
                end
            end
            UART_DONE: begin
                busy_d  = 1'b0;
                state_d = UART_IDLE;
            end
            default: state_d = UART_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= UART_IDLE;
            idx_q   <= '0;
            csum_q  <= '0;
            snap_q  <= '0;
            us_q    <= 1'b0;
            sdata_q <= '0;
            busy_q  <= 1'b0;
            sdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            snap_q  <= snap_d;
            us_q    <= us_d;
            sdata_q <= sdata_d;
            busy_q  <= busy_d;
            sdone_q <= sdone_d;
        end
    end

    assign uart_send = us_q;
    assign send_data = sdata_q;
    assign busy      = busy_q;
    assign send_done = sdone_q;
    assign sta       = state_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Self-checking bench for uart_frame_tx with a UART TX responder model.
// Two configurations share one responder selected by sel.
module tb_uart_frame_tx;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        logic [31:0] d;
        bit          zap;
        logic [47:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        send_a, send_b;
    logic [31:0] data_a, data_b;
    logic        us_a, us_b;
    logic [7:0]  sd_a, sd_b;
    logic        busy_a, busy_b;
    logic        sdone_a, sdone_b;
    logic [1:0]  sta_a, sta_b;
    logic        tx_done, spur, usd;

    assign usd = tx_done | spur;

    always #5 clk = ~clk;

    uart_frame_tx #(
        .NUM_BYTES (4)
    ) dut_a (
        .clk            (clk),
        .rst            (rst),
        .send           (send_a),
        .data           (data_a),
        .uart_send      (us_a),
        .send_data      (sd_a),
        .uart_send_done (usd),
        .busy           (busy_a),
        .send_done      (sdone_a),
        .sta            (sta_a)
    );

    uart_frame_tx #(
        .NUM_BYTES (4),
        .MSB_FIRST (1'b1),
        .HEADER_EN (1'b0),
        .CSUM_EN   (1'b0)
    ) dut_b (
        .clk            (clk),
        .rst            (rst),
        .send           (send_b),
        .data           (data_b),
        .uart_send      (us_b),
        .send_data      (sd_b),
        .uart_send_done (usd),
        .busy           (busy_b),
        .send_done      (sdone_b),
        .sta            (sta_b)
    );

    int   n_err = 0;
    int   n_chk = 0;
    int   sel = 0;
    int   tx_time = 10;
    int   done_len = 1;
    int   done_cnt = 0;
    bq_t  cap;

    // UART TX responder: captures each byte on uart_send rising,
    // raises done tx_time cycles later for done_len cycles.
    initial begin
        int  cnt;
        int  hold;
        bit  prev;
        logic cu;
        logic [7:0] cd;
        tx_done = 1'b0;
        cnt = 0;
        hold = 0;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            cu = (sel == 0) ? us_a : us_b;
            cd = (sel == 0) ? sd_a : sd_b;
            if (((sel == 0) ? sdone_a : sdone_b) === 1'b1) done_cnt++;
            if (cu && !prev) begin
                cap.push_back(cd);
                cnt = 0;
            end
            if (hold > 0) begin
                hold--;
                if (hold == 0) tx_done = 1'b0;
            end else if (cu) begin
                cnt++;
                if (cnt >= tx_time) begin
                    tx_done = 1'b1;
                    hold = done_len;
                end
            end
            prev = cu;
        end
    end

    function automatic void model(input logic [31:0] d, input bit msb,
                                  input bit hdr, input bit cs, output bq_t q);
        int s;
        logic [7:0] b;
        q = {};
        s = 0;
        if (hdr) q.push_back(8'hAA);
        for (int k = 0; k < 4; k++) begin
            b = msb ? d[8*(3-k) +: 8] : d[8*k +: 8];
            q.push_back(b);
            s += int'(b);
        end
        if (cs) q.push_back(8'(s % 256));
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic cmp_frame(input string name, input bq_t exp);
        logic [31:0] g;
        chk({name, " len"}, cap.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            g = (i < cap.size()) ? {24'h0, cap[i]} : 32'hFFFF_FFFF;
            chk($sformatf("%s byte%0d", name, i), g, {24'h0, exp[i]});
        end
    endtask

    task automatic drive(input int s, input logic v, input logic [31:0] d);
        if (s == 0) begin
            send_a = v;
            data_a = d;
        end else begin
            send_b = v;
            data_b = d;
        end
    endtask

    task automatic run_frame(input string name, input int s, input logic [31:0] d,
                             input bit zap, input bit poke, input bq_t exp);
        int d0;
        int i;
        sel = s;
        cap.delete();
        d0 = done_cnt;
        drive(s, 1'b1, d);
        @(negedge clk);
        drive(s, 1'b0, zap ? 32'h0 : d);
        i = 0;
        while (i < 2000 && done_cnt == d0) begin
            @(negedge clk);
            if (poke && i == 30) drive(s, 1'b1, zap ? 32'h0 : d);
            if (poke && i == 31) drive(s, 1'b0, zap ? 32'h0 : d);
            i++;
        end
        repeat (4) @(negedge clk);
        chk({name, " done pulses"}, done_cnt - d0, 1);
        chk({name, " busy low"}, (s == 0) ? busy_a : busy_b, 1'b0);
        cmp_frame(name, exp);
    endtask

    initial begin
        vec_t tv[5];
        bq_t  e;
        bq_t  e3;
        int   d0;
        int   i;
        logic [31:0] rd;

        tv[0] = '{32'h04030201, 1'b0, 48'hAA_01_02_03_04_0A};
        tv[1] = '{32'h0003FFFF, 1'b1, 48'hAA_FF_FF_03_00_01};
        tv[2] = '{32'h80808080, 1'b0, 48'hAA_80_80_80_80_00};
        tv[3] = '{32'h00000000, 1'b0, 48'hAA_00_00_00_00_00};
        tv[4] = '{32'hFFFFFFFF, 1'b0, 48'hAA_FF_FF_FF_FF_FC};

        rst = 1'b0;
        spur = 1'b0;
        send_a = 1'b0;
        send_b = 1'b0;
        data_a = 32'h0;
        data_b = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst us", {us_b, us_a}, 2'b00);
        chk("rst sd", {sd_b, sd_a}, 16'h0);
        chk("rst busy", {busy_b, busy_a}, 2'b00);
        chk("rst sdone", {sdone_b, sdone_a}, 2'b00);
        chk("rst sta", {sta_b, sta_a}, 4'h0);
        rst = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 5; t++) begin
            e = {};
            for (int j = 5; j >= 0; j--) e.push_back(tv[t].exp[8*j +: 8]);
            run_frame($sformatf("vec%0d", t), 0, tv[t].d, tv[t].zap, 1'b0, e);
        end

        e = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_frame("msb_nohdr", 1, 32'hDEADBEEF, 1'b0, 1'b0, e);

        for (int t = 0; t < 6; t++) begin
            rd = $urandom;
            tx_time = $urandom_range(1, 12);
            model(rd, 1'b0, 1'b1, 1'b1, e);
            run_frame($sformatf("randA%0d", t), 0, rd, 1'b0, 1'b0, e);
            rd = $urandom;
            model(rd, 1'b1, 1'b0, 1'b0, e);
            run_frame($sformatf("randB%0d", t), 1, rd, 1'b0, 1'b0, e);
        end
        tx_time = 10;

        model(32'h11223344, 1'b0, 1'b1, 1'b1, e);
        run_frame("busy_poke", 0, 32'h11223344, 1'b0, 1'b1, e);

        done_len = 2;
        rd = $urandom;
        model(rd, 1'b0, 1'b1, 1'b1, e);
        run_frame("done_long", 0, rd, 1'b0, 1'b0, e);
        done_len = 1;

        sel = 0;
        cap.delete();
        d0 = done_cnt;
        rd = 32'hA5C3_0F12;
        drive(0, 1'b1, rd);
        i = 0;
        while (i < 3000 && done_cnt - d0 < 3) begin
            @(negedge clk);
            i++;
        end
        drive(0, 1'b0, rd);
        repeat (60) @(negedge clk);
        chk("b2b done pulses", done_cnt - d0, 3);
        model(rd, 1'b0, 1'b1, 1'b1, e);
        e3 = {e, e, e};
        cmp_frame("b2b", e3);

        cap.delete();
        drive(0, 1'b1, 32'h55667788);
        @(negedge clk);
        drive(0, 1'b0, 32'h55667788);
        i = 0;
        while (i < 500 && cap.size() < 3) begin
            @(negedge clk);
            i++;
        end
        chk("rst mid reached", cap.size(), 3);
        d0 = done_cnt;
        #2 rst = 1'b0;
        #1;
        chk("rst mid us", us_a, 1'b0);
        chk("rst mid sd", sd_a, 8'h00);
        chk("rst mid busy", busy_a, 1'b0);
        chk("rst mid sta", sta_a, 2'd0);
        chk("rst mid sdone", sdone_a, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        chk("rst mid no done", done_cnt - d0, 0);
        model(32'h99AABBCC, 1'b0, 1'b1, 1'b1, e);
        run_frame("after_rst", 0, 32'h99AABBCC, 1'b0, 1'b0, e);

        spur = 1'b1;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            chk($sformatf("spur sta%0d", t), sta_a, 2'd0);
            chk($sformatf("spur busy%0d", t), busy_a, 1'b0);
            chk($sformatf("spur us%0d", t), us_a, 1'b0);
        end
        spur = 1'b0;
        chk("idle b sta", sta_b, 2'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
